// File: rtl/bcd_to_bin_loader_if.sv
// Digit-entry bus between the time-setting keypad logic and the BCD loader.
// The master drives the digit strobe and cancel. The slave (the loader)
// returns its status, the load/err pulses, the loaded value and the echoed
// tens digit.
interface bcd_to_bin_loader_if;
    logic       digit_valid;
    logic [3:0] digit;
    logic       cancel;
    logic       busy;
    logic       load;
    logic [5:0] value;
    logic       err;
    logic [2:0] tens_out;

    modport master (
        output digit_valid, digit, cancel,
        input  busy, load, value, err, tens_out
    );

    modport slave (
        input  digit_valid, digit, cancel,
        output busy, load, value, err, tens_out
    );
endinterface

// File: rtl/bcd_to_bin_loader.sv
// Two-digit BCD time-setting loader. It captures a tens digit, waits a bounded
// time for the units digit, range-checks tens*10+units against MAX_VAL, and
// emits a one-cycle load pulse with the binary value. It emits a one-cycle err
// pulse on a bad digit, an out-of-range result or a timeout.
module bcd_to_bin_loader #(
    parameter int MAX_VAL = 59,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_to_bin_loader_if.slave   io
);

    typedef enum logic {IDLE, WAIT_UNITS} state_t;

    // Largest tens digit that can still lead to a legal value (at most 6).
    localparam logic [3:0] TENS_MAX = 4'(MAX_VAL / 10);
    localparam logic [6:0] MAX_SUM  = 7'(MAX_VAL);
    localparam logic [7:0] TMR_LAST = 8'(TIMEOUT - 1);

    // tens*10 + units, where tens*10 is built as (tens<<3)+(tens<<1).
    function automatic logic [6:0] bcd_sum(input logic [2:0] t, input logic [3:0] u);
        logic [6:0] t7;
        t7 = {4'b0000, t};
        return (t7 << 3) + (t7 << 1) + {3'b000, u};
    endfunction

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [2:0] tens_q,  tens_d;
    logic [5:0] value_q, value_d;
    logic       load_q,  load_d;
    logic       err_q,   err_d;
    logic [6:0] sum;

    assign sum = bcd_sum(tens_q, io.digit);

    // State, timer and all outputs registered; reset discards any entry silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            tens_q  <= '0;
            value_q <= '0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            tens_q  <= tens_d;
            value_q <= value_d;
            load_q  <= load_d;
            err_q   <= err_d;
        end
    end

    // Next-state and output decode; within WAIT_UNITS the priority is cancel > digit > timeout.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        tens_d  = tens_q;
        value_d = value_q;
        load_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                tens_d = '0;
                if (io.digit_valid) begin
                    if (io.digit <= TENS_MAX) begin
                        tens_d  = io.digit[2:0];
                        timer_d = '0;
                        state_d = WAIT_UNITS;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT_UNITS: begin
                timer_d = (timer_q == TMR_LAST) ? timer_q : timer_q + 8'd1;
                if (io.cancel) begin
                    state_d = IDLE;
                    tens_d  = '0;
                end else if (io.digit_valid) begin
                    state_d = IDLE;
                    tens_d  = '0;
                    if (io.digit > 4'd9) begin
                        err_d = 1'b1;
                    end else if (sum <= MAX_SUM) begin
                        value_d = sum[5:0];
                        load_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (timer_q == TMR_LAST) begin
                    state_d = IDLE;
                    tens_d  = '0;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tens_d  = '0;
            end
        endcase
    end

    assign io.busy     = (state_q == WAIT_UNITS);
    assign io.load     = load_q;
    assign io.err      = err_q;
    assign io.value    = value_q;
    assign io.tens_out = tens_q;

endmodule

// File: tb/tb_bcd_to_bin_loader.sv
// Bench for bcd_to_bin_loader. It runs two instances: A (MAX_VAL=59,
// TIMEOUT=8) and B (MAX_VAL=23, TIMEOUT=255). Expected load/err events are
// queued when stimulus is driven and popped by a monitor as the DUT
// produces them.
module tb_bcd_to_bin_loader;

    localparam int MAX_A = 59;
    localparam int TO_A  = 8;
    localparam int MAX_B = 23;
    localparam int TO_B  = 255;

    typedef struct packed {
        logic       is_load;
        logic [5:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_to_bin_loader_if ifa ();
    bcd_to_bin_loader_if ifb ();

    bcd_to_bin_loader #(.MAX_VAL(MAX_A), .TIMEOUT(TO_A)) dut_a (.clk(clk), .rst(rst), .io(ifa.slave));
    bcd_to_bin_loader #(.MAX_VAL(MAX_B), .TIMEOUT(TO_B)) dut_b (.clk(clk), .rst(rst), .io(ifb.slave));

    logic       dv [2];
    logic [3:0] dg [2];
    logic       cn [2];
    logic       ld [2];
    logic       er [2];
    logic       bs [2];
    logic [5:0] vl [2];
    logic [2:0] to [2];

    assign ifa.digit_valid = dv[0];
    assign ifa.digit       = dg[0];
    assign ifa.cancel      = cn[0];
    assign ifb.digit_valid = dv[1];
    assign ifb.digit       = dg[1];
    assign ifb.cancel      = cn[1];
    assign ld[0] = ifa.load;   assign ld[1] = ifb.load;
    assign er[0] = ifa.err;    assign er[1] = ifb.err;
    assign bs[0] = ifa.busy;   assign bs[1] = ifb.busy;
    assign vl[0] = ifa.value;  assign vl[1] = ifb.value;
    assign to[0] = ifa.tens_out; assign to[1] = ifb.tens_out;

    exp_t q0[$];
    exp_t q1[$];
    int   nchk = 0;
    int   nerr = 0;
    int   vexp [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put(input int d, input logic [3:0] v, input logic c);
        dv[d] = 1'b1;
        dg[d] = v;
        cn[d] = c;
        tick(1);
        dv[d] = 1'b0;
        cn[d] = 1'b0;
    endtask

    // Drive a tens digit; a digit above MAX_VAL/10 must err and stay idle.
    task automatic tens(input int d, input int t);
        int   mx;
        exp_t e;
        mx = (d == 0) ? MAX_A : MAX_B;
        if (t > mx / 10) begin
            e.is_load = 1'b0;
            e.val     = '0;
            push(d, e);
        end
        put(d, 4'(t), 1'b0);
        if (t <= mx / 10) begin
            check($sformatf("busy_tens_%0d", d), bs[d], 1);
            check($sformatf("tens_out_%0d", d), to[d], t);
        end else begin
            check($sformatf("err_tens_%0d", d), er[d], 1);
            check($sformatf("busy_badtens_%0d", d), bs[d], 0);
        end
    endtask

    // Drive a units digit while waiting; predict load or err from MAX_VAL.
    task automatic units(input int d, input int t, input int u);
        int   mx;
        int   sum;
        exp_t e;
        mx  = (d == 0) ? MAX_A : MAX_B;
        sum = t * 10 + u;
        if (u <= 9 && sum <= mx) begin
            e.is_load = 1'b1;
            e.val     = 6'(sum);
            vexp[d]   = sum;
        end else begin
            e.is_load = 1'b0;
            e.val     = '0;
        end
        push(d, e);
        put(d, 4'(u), 1'b0);
        check($sformatf("load_now_%0d", d), ld[d], e.is_load);
        check($sformatf("err_now_%0d", d), er[d], !e.is_load);
        check($sformatf("value_%0d", d), vl[d], vexp[d]);
        check($sformatf("busy_after_%0d", d), bs[d], 0);
        check($sformatf("tens_idle_%0d", d), to[d], 0);
    endtask

    // Scoreboard monitor: every load/err pulse must match the next queued event.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int d = 0; d < 2; d++) begin
                if (ld[d] === 1'b1 || er[d] === 1'b1) begin
                    exp_t e;
                    int   n;
                    n = (d == 0) ? q0.size() : q1.size();
                    if (n == 0) begin
                        check($sformatf("spurious_evt_%0d", d), {ld[d], er[d]}, 0);
                    end else begin
                        if (d == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        check($sformatf("evt_load_%0d", d), ld[d], e.is_load);
                        check($sformatf("evt_err_%0d", d), er[d], !e.is_load);
                        if (e.is_load) check($sformatf("evt_value_%0d", d), vl[d], e.val);
                    end
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            dv[d] = 1'b0;
            dg[d] = '0;
            cn[d] = 1'b0;
            vexp[d] = 0;
        end
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_busy_%0d", d), bs[d], 0);
            check($sformatf("rst_load_%0d", d), ld[d], 0);
            check($sformatf("rst_err_%0d", d), er[d], 0);
            check($sformatf("rst_value_%0d", d), vl[d], 0);
            check($sformatf("rst_tens_%0d", d), to[d], 0);
        end
        tick(2);
        rst = 1'b0;
        tick(1);

        // Basic entry 4,7 on A with two idle cycles between the digits.
        tens(0, 4);
        tick(2);
        check("busy_hold", bs[0], 1);
        check("tens_hold", to[0], 4);
        units(0, 4, 7);

        // B (limit 23): load 19, then 24 out of range, tens 3 rejected, 23 at the boundary.
        tens(1, 1);
        units(1, 1, 9);
        tens(1, 2);
        units(1, 2, 4);
        tens(1, 3);
        tens(1, 2);
        units(1, 2, 3);

        // A: tens 6 above the limit; 59 at the boundary.
        tens(0, 6);
        tens(0, 5);
        units(0, 5, 9);

        // A timeout: err exactly 8 cycles after capture.
        tens(0, 5);
        begin
            exp_t e;
            e.is_load = 1'b0;
            e.val     = '0;
            push(0, e);
        end
        tick(6);
        check("to_busy_early", bs[0], 1);
        tick(1);
        check("to_busy_last", bs[0], 1);
        check("to_err_early", er[0], 0);
        tick(1);
        check("to_err", er[0], 1);
        check("to_busy_drop", bs[0], 0);
        check("to_value_kept", vl[0], vexp[0]);

        // A units digit arriving when the timer reaches its last count still wins.
        tens(0, 5);
        tick(7);
        check("late_busy", bs[0], 1);
        units(0, 5, 8);

        // Cancel together with a digit discards the entry; next digit is a new tens.
        tens(0, 1);
        put(0, 4'd6, 1'b1);
        check("cancel_busy", bs[0], 0);
        check("cancel_load", ld[0], 0);
        check("cancel_err", er[0], 0);
        check("cancel_tens", to[0], 0);
        check("cancel_value", vl[0], vexp[0]);
        tens(0, 1);
        units(0, 1, 2);

        // Cancel in IDLE is ignored, also alongside a tens digit.
        cn[0] = 1'b1;
        tick(1);
        cn[0] = 1'b0;
        check("idle_cancel_busy", bs[0], 0);
        put(0, 4'd3, 1'b1);
        check("idle_cancel_tens", to[0], 3);
        units(0, 3, 1);

        // Back-to-back entries with no dead cycle.
        tens(0, 2);
        units(0, 2, 3);
        tens(0, 4);
        units(0, 4, 0);

        // Illegal BCD digits.
        tens(0, 10);
        tens(0, 2);
        units(0, 2, 15);

        // Asynchronous reset mid-entry on both instances.
        tens(0, 5);
        tens(1, 2);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("arst_busy_%0d", d), bs[d], 0);
            check($sformatf("arst_load_%0d", d), ld[d], 0);
            check($sformatf("arst_err_%0d", d), er[d], 0);
            check($sformatf("arst_value_%0d", d), vl[d], 0);
            check($sformatf("arst_tens_%0d", d), to[d], 0);
            vexp[d] = 0;
        end
        q0.delete();
        q1.delete();
        tick(1);
        rst = 1'b0;
        tick(1);
        tens(0, 0);
        units(0, 0, 0);

        tick(3);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
